ram_arbiter: RTL and testbench

Shares the single-ported off-chip SRAM between the instruction-fetch port and the data-access port of the MEM stage. A three-state controller grants one requester at a time and drives the SRAM strobes, address, byte enables and bidirectional data with fixed timing. It returns a one-cycle acknowledge with registered read data and raises a pipeline stall request while any accepted request is outstanding. It sits between the IF/MEM stages and the board SRAM pins.

---
 rtl/ram_arbiter_pkg.sv | 22 ++
 rtl/ram_arbiter_if.sv | 32 +++
 rtl/ram_wait_cnt.sv | 26 ++
 rtl/ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: bus widths, FSM state and grant encodings.
package ram_arbiter_pkg;

  typedef logic [31:0] RegBus;
  typedef logic [3:0]  RamSel;
  typedef logic [31:0] DataAddrBus;
  typedef logic [19:0] SramAddrBus;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbAccess = 2'd1,
    ArbAck    = 2'd2
  } arb_state_e;

  typedef enum logic {
    GntInst = 1'b0,
    GntData = 1'b1
  } arb_gnt_e;

  localparam logic [3:0] StrobeIdle = 4'b1110;  // {ce_n, oe_n, we_n, data_oe}

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle between the IF/MEM stages and the SRAM arbiter.
interface ram_arbiter_if;
  import ram_arbiter_pkg::*;

  logic       inst_req_i;
  DataAddrBus inst_addr_i;
  RegBus      inst_data_o;
  logic       inst_ack_o;

  logic       data_req_i;
  logic       data_we_i;
  RamSel      data_sel_i;
  DataAddrBus data_addr_i;
  RegBus      data_wdata_i;
  RegBus      data_rdata_o;
  logic       data_ack_o;

  logic       stall_req_o;

  modport slave (
    input  inst_req_i, inst_addr_i,
    input  data_req_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
    output inst_data_o, inst_ack_o, data_rdata_o, data_ack_o, stall_req_o
  );

  modport master (
    output inst_req_i, inst_addr_i,
    output data_req_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
    input  inst_data_o, inst_ack_o, data_rdata_o, data_ack_o, stall_req_o
  );

endinterface

// File: rtl/ram_wait_cnt.sv
// SRAM wait-state counter: loads on ACCESS entry, counts down, flags zero.
// Only instantiated when RAM_ARB_WAIT_EN is defined.
module ram_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_dec,
  input  logic [2:0] i_load_val,
  output logic       o_zero
);

  logic [2:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 3'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  assign o_zero = (r_cnt == 3'd0);

endmodule

// File: rtl/ram_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and MEM data access (data wins).
// Define RAM_ARB_WAIT_EN to stretch ACCESS by WAIT_CYCLES extra cycles.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus,
  output SramAddrBus    ram_addr_o,
  output RamSel         ram_be_n_o,
  output logic          ram_ce_n_o,
  output logic          ram_oe_n_o,
  output logic          ram_we_n_o,
  output RegBus         ram_data_o,
  output logic          ram_data_oe_o,
  input  RegBus         ram_data_i
);

  arb_state_e r_state;
  arb_gnt_e   r_gnt;
  logic       r_we;
  SramAddrBus r_ram_addr;
  RamSel      r_ram_be_n;
  logic       r_ram_ce_n;
  logic       r_ram_oe_n;
  logic       r_ram_we_n;
  RegBus      r_ram_data;
  logic       r_ram_data_oe;
  RegBus      r_inst_data;
  RegBus      r_data_rdata;
  logic       r_inst_ack;
  logic       r_data_ack;

  logic w_any_req;
  logic w_access_last;
  logic w_unused_addr;

  assign w_any_req = bus.data_req_i | bus.inst_req_i;

`ifdef RAM_ARB_WAIT_EN
  logic w_cnt_zero;

  ram_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     ((r_state == ArbIdle) && w_any_req),
    .i_dec      ((r_state == ArbAccess) && !w_cnt_zero),
    .i_load_val (3'(WAIT_CYCLES)),
    .o_zero     (w_cnt_zero)
  );

  assign w_access_last = w_cnt_zero;
`else
  logic w_unused_wait;

  assign w_unused_wait = |3'(WAIT_CYCLES);
  assign w_access_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ArbIdle;
      r_gnt         <= GntInst;
      r_we          <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_be_n    <= 4'hF;
      r_ram_ce_n    <= 1'b1;
      r_ram_oe_n    <= 1'b1;
      r_ram_we_n    <= 1'b1;
      r_ram_data    <= '0;
      r_ram_data_oe <= 1'b0;
      r_inst_data   <= '0;
      r_data_rdata  <= '0;
      r_inst_ack    <= 1'b0;
      r_data_ack    <= 1'b0;
    end else begin
      unique case (r_state)
        ArbIdle: begin
          r_inst_ack <= 1'b0;
          r_data_ack <= 1'b0;
          // Data belongs to the older instruction, so it always wins a tie.
          if (bus.data_req_i) begin
            r_gnt         <= GntData;
            r_we          <= bus.data_we_i;
            r_ram_addr    <= bus.data_addr_i[21:2];
            r_ram_be_n    <= ~bus.data_sel_i;
            r_ram_data    <= bus.data_wdata_i;
            r_ram_ce_n    <= 1'b0;
            r_ram_oe_n    <= bus.data_we_i;
            r_ram_we_n    <= ~bus.data_we_i;
            r_ram_data_oe <= bus.data_we_i;
            r_state       <= ArbAccess;
          end else if (bus.inst_req_i) begin
            r_gnt         <= GntInst;
            r_we          <= 1'b0;
            r_ram_addr    <= bus.inst_addr_i[21:2];
            r_ram_be_n    <= 4'h0;
            r_ram_ce_n    <= 1'b0;
            r_ram_oe_n    <= 1'b0;
            r_ram_we_n    <= 1'b1;
            r_ram_data_oe <= 1'b0;
            r_state       <= ArbAccess;
          end
        end
        ArbAccess: begin
          if (w_access_last) begin
            if (!r_we) begin
              if (r_gnt == GntData) r_data_rdata <= ram_data_i;
              else                  r_inst_data  <= ram_data_i;
            end
            r_ram_ce_n    <= 1'b1;
            r_ram_oe_n    <= 1'b1;
            r_ram_we_n    <= 1'b1;
            r_ram_be_n    <= 4'hF;
            r_ram_data_oe <= 1'b0;
            r_data_ack    <= (r_gnt == GntData);
            r_inst_ack    <= (r_gnt == GntInst);
            r_state       <= ArbAck;
          end
        end
        ArbAck: begin
          r_inst_ack <= 1'b0;
          r_data_ack <= 1'b0;
          r_state    <= ArbIdle;
        end
        default: r_state <= ArbIdle;
      endcase
    end
  end

  // Only the word address within a 4 MiB window reaches the pins.
  assign w_unused_addr = ^{bus.inst_addr_i[31:22], bus.inst_addr_i[1:0],
                           bus.data_addr_i[31:22], bus.data_addr_i[1:0]};

  assign bus.inst_data_o  = r_inst_data;
  assign bus.inst_ack_o   = r_inst_ack;
  assign bus.data_rdata_o = r_data_rdata;
  assign bus.data_ack_o   = r_data_ack;
  assign bus.stall_req_o  = (bus.data_req_i & ~r_data_ack) | (bus.inst_req_i & ~r_inst_ack);

  assign ram_addr_o    = r_ram_addr;
  assign ram_be_n_o    = r_ram_be_n;
  assign ram_ce_n_o    = r_ram_ce_n;
  assign ram_oe_n_o    = r_ram_oe_n;
  assign ram_we_n_o    = r_ram_we_n;
  assign ram_data_o    = r_ram_data;
  assign ram_data_oe_o = r_ram_data_oe;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, scoreboard of acks, corner sequences.
module tb_ram_arbiter;

`ifdef RAM_ARB_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif

  logic        clk;
  logic        rst;
  logic [19:0] ram_addr_o;
  logic [3:0]  ram_be_n_o;
  logic        ram_ce_n_o;
  logic        ram_oe_n_o;
  logic        ram_we_n_o;
  logic [31:0] ram_data_o;
  logic        ram_data_oe_o;
  logic [31:0] ram_data_i;
  logic [3:0]  strobes;
  logic [1:0]  acks;

  ram_arbiter_if bus();

  ram_arbiter #(
    .WAIT_CYCLES (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .ram_addr_o    (ram_addr_o),
    .ram_be_n_o    (ram_be_n_o),
    .ram_ce_n_o    (ram_ce_n_o),
    .ram_oe_n_o    (ram_oe_n_o),
    .ram_we_n_o    (ram_we_n_o),
    .ram_data_o    (ram_data_o),
    .ram_data_oe_o (ram_data_oe_o),
    .ram_data_i    (ram_data_i)
  );

  assign strobes = {ram_ce_n_o, ram_oe_n_o, ram_we_n_o, ram_data_oe_o};
  assign acks    = {bus.data_ack_o, bus.inst_ack_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          port;  // 1 = data, 0 = inst
    logic [31:0] data;
  } sb_t;

  typedef struct {
    bit          port;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [19:0] exp_addr;
    logic [3:0]  exp_be_n;
  } vec_t;

  sb_t         sb[$];
  vec_t        vecs[6];
  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] m_inst_data;
  logic [31:0] m_data_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit port, input logic we, input logic [31:0] rdata);
    sb_t e;
    e.port = port;
    if (!port) begin
      m_inst_data = rdata;
      e.data      = rdata;
    end else if (we) begin
      e.data = m_data_rdata;
    end else begin
      m_data_rdata = rdata;
      e.data       = rdata;
    end
    sb.push_back(e);
  endtask

  // Scoreboard: every ack pops one expected completion.
  always @(negedge clk) begin
    sb_t e;
    if (rst && (acks != 2'b00)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(acks), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", 32'(acks), e.port ? 32'd2 : 32'd1);
        chk("ack_rdata", e.port ? bus.data_rdata_o : bus.inst_data_o, e.data);
      end
    end
  end

  task automatic run_access(input vec_t v);
    int         cyc;
    bit         got;
    logic [3:0] exp_str;
    exp_str = (v.port && v.we) ? 4'b0101 : 4'b0010;
    bus.data_we_i    = v.we;
    bus.data_sel_i   = v.sel;
    bus.data_addr_i  = v.addr;
    bus.inst_addr_i  = v.addr;
    bus.data_wdata_i = v.wdata;
    ram_data_i       = ~v.rdata;
    push_exp(v.port, v.port ? v.we : 1'b0, v.rdata);
    if (v.port) bus.data_req_i = 1'b1;
    else        bus.inst_req_i = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc <= W + 1) begin
        chk("acc_strobes", 32'(strobes), 32'(exp_str));
        chk("acc_be_n", 32'(ram_be_n_o), 32'(v.exp_be_n));
        chk("acc_addr", 32'(ram_addr_o), 32'(v.exp_addr));
        chk("acc_no_ack", 32'(acks), 32'd0);
        chk("acc_stall", 32'(bus.stall_req_o), 32'd1);
        if (v.port && v.we) chk("acc_wdata", ram_data_o, v.wdata);
        if (cyc == W + 1) ram_data_i = v.rdata;
      end else if (acks != 2'b00) begin
        got = 1'b1;
        chk("latency", 32'(cyc), 32'(W + 2));
        chk("ack_strobes", 32'(strobes), 32'b1110);
        chk("ack_be_n", 32'(ram_be_n_o), 32'hF);
        chk("ack_stall", 32'(bus.stall_req_o), 32'd0);
        bus.inst_req_i = 1'b0;
        bus.data_req_i = 1'b0;
        ram_data_i     = 32'h0BAD_0BAD;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("hold_data", v.port ? bus.data_rdata_o : bus.inst_data_o,
        v.port ? m_data_rdata : m_inst_data);
    chk("idle_no_ack", 32'(acks), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'hF,    32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 20'h00004, 4'h0};
    vecs[1] = '{1'b1, 1'b1, 4'b0100, 32'h0000_0020, 32'h00AB_0000, 32'h7777_7777, 20'h00008, 4'b1011};
    vecs[2] = '{1'b0, 1'b1, 4'h0,    32'hFFC0_0004, 32'hFFFF_FFFF, 32'h1234_5678, 20'h00001, 4'h0};
    vecs[3] = '{1'b1, 1'b0, 4'b0011, 32'h003F_FFFF, 32'h0,         32'hA5A5_5A5A, 20'hFFFFF, 4'b1100};
    vecs[4] = '{1'b1, 1'b1, 4'b0001, 32'h0040_0008, 32'h0000_00CC, 32'h3333_3333, 20'h00002, 4'b1110};
    vecs[5] = '{1'b0, 1'b0, 4'hF,    32'h0000_0003, 32'h0,         32'hCAFE_F00D, 20'h00000, 4'h0};

    rst              = 1'b1;
    bus.inst_req_i   = 1'b0;
    bus.inst_addr_i  = '0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_sel_i   = '0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
    ram_data_i       = '0;
    m_inst_data      = '0;
    m_data_rdata     = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_strobes", 32'(strobes), 32'b1110);
    chk("rst_be_n", 32'(ram_be_n_o), 32'hF);
    chk("rst_addr", 32'(ram_addr_o), 32'd0);
    chk("rst_wdata", ram_data_o, 32'd0);
    chk("rst_acks", 32'(acks), 32'd0);
    chk("rst_inst_data", bus.inst_data_o, 32'd0);
    chk("rst_data_rdata", bus.data_rdata_o, 32'd0);
    chk("rst_stall", 32'(bus.stall_req_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_access(vecs[i]);

    // Contention: data first, inst on the following IDLE.
    bus.inst_addr_i = 32'h0000_0100;
    bus.data_addr_i = 32'h0000_0200;
    bus.data_we_i   = 1'b0;
    bus.data_sel_i  = 4'hF;
    ram_data_i      = 32'h1111_1111;
    push_exp(1'b1, 1'b0, 32'h1111_1111);
    push_exp(1'b0, 1'b0, 32'h2222_2222);
    bus.inst_req_i  = 1'b1;
    bus.data_req_i  = 1'b1;
    for (int c = 1; c <= 2 * W + 5; c++) begin
      @(negedge clk);
      chk("cont_acks", 32'(acks), 32'({c == 2 * W + 5, c == W + 2}) == 32'd0 ? 32'd0 :
          ((c == W + 2) ? 32'd2 : 32'd1));
      chk("cont_stall", 32'(bus.stall_req_o), 32'(c != 2 * W + 5));
      if (c == 1)     chk("cont_data_addr", 32'(ram_addr_o), 32'h80);
      if (c == W + 4) chk("cont_inst_addr", 32'(ram_addr_o), 32'h40);
      if (c == W + 2) begin
        bus.data_req_i = 1'b0;
        ram_data_i     = 32'h2222_2222;
      end
      if (c == 2 * W + 5) bus.inst_req_i = 1'b0;
    end
    @(negedge clk);

    // Back-to-back data reads with the request held through the ack.
    bus.data_addr_i = 32'h0000_0040;
    ram_data_i      = 32'h0102_0304;
    push_exp(1'b1, 1'b0, 32'h0102_0304);
    bus.data_req_i  = 1'b1;
    for (int c = 1; c <= 2 * W + 5; c++) begin
      @(negedge clk);
      chk("b2b_acks", 32'(acks), 32'((c == W + 2) || (c == 2 * W + 5)) << 1);
      if (c == 1) chk("b2b_addr0", 32'(ram_addr_o), 32'h10);
      if (c == W + 2) begin
        bus.data_addr_i = 32'h0000_0044;
        ram_data_i      = 32'hF0E0_D0C0;
        push_exp(1'b1, 1'b0, 32'h0F1F_2F3F);
      end
      if (c == W + 4)     chk("b2b_addr1", 32'(ram_addr_o), 32'h11);
      if (c == 2 * W + 4) ram_data_i = 32'h0F1F_2F3F;
      if (c == 2 * W + 5) bus.data_req_i = 1'b0;
    end
    @(negedge clk);

    // Reset in the middle of ACCESS: access is dropped, no ack.
    bus.data_addr_i = 32'h0000_0080;
    bus.data_we_i   = 1'b0;
    ram_data_i      = 32'h5555_AAAA;
    bus.data_req_i  = 1'b1;
    @(negedge clk);
    chk("rst_pre_ce", 32'(ram_ce_n_o), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_strobes", 32'(strobes), 32'b1110);
    chk("rst_mid_be_n", 32'(ram_be_n_o), 32'hF);
    chk("rst_mid_addr", 32'(ram_addr_o), 32'd0);
    chk("rst_mid_rdata", bus.data_rdata_o, 32'd0);
    chk("rst_mid_inst", bus.inst_data_o, 32'd0);
    m_data_rdata   = '0;
    m_inst_data    = '0;
    bus.data_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (W + 4) begin
      @(negedge clk);
      chk("rst_no_ack", 32'(acks), 32'd0);
    end
    run_access(vecs[0]);
    run_access(vecs[5]);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
